// File: rtl/mig_cp_ptab_xlat.sv
// rtl/mig_cp_ptab_xlat.sv - DSid partition table with pipelined per-channel base+offset translation
// Optional feature macro: MIG_CP_PTAB_STATS_EN (per-entry hit counters on col 4)
module mig_cp_ptab_xlat #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_PORTS   = 2,
  parameter int TAG_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            sel,
  input  logic [14:0]                     col,
  input  logic [14:0]                     row,
  input  logic [63:0]                     wdata,
  input  logic                            wen,
  output logic [63:0]                     rdata,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_PORTS-1:0]            resp_valid,
  input  logic [NUM_PORTS-1:0]            resp_ready,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] resp_addr,
  output logic [NUM_PORTS-1:0]            resp_hit,
  output logic [NUM_PORTS-1:0]            resp_oob
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  // Partition table storage
  logic [TAG_WIDTH-1:0]   tab_tag  [NUM_ENTRIES];
  logic [ADDR_WIDTH-1:0]  tab_base [NUM_ENTRIES];
  logic [ADDR_WIDTH-1:0]  tab_len  [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] tab_valid;

  logic             row_in;
  logic [IDX_W-1:0] row_idx;
  logic             wr_en;
  logic             unused_wdata;

  assign row_in       = ({17'd0, row} < 32'(NUM_ENTRIES));
  assign row_idx      = row[IDX_W-1:0];
  assign wr_en        = sel & wen & row_in;
  assign unused_wdata = ^wdata;

  // Per-channel lookup result against the current (pre-write) table contents
  logic [NUM_PORTS-1:0] lk_hit;
  logic [IDX_W-1:0]     lk_idx [NUM_PORTS];

  // Pipeline state
  logic [NUM_PORTS-1:0]  s1_valid, s1_hit, s2_valid, s2_hit, s2_oob;
  logic [NUM_PORTS-1:0]  s2_ready, s1_adv, accept;
  logic [ADDR_WIDTH-1:0] s1_off  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] s1_base [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] s1_len  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] s2_addr [NUM_PORTS];

`ifdef MIG_CP_PTAB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q   [NUM_ENTRIES];
  logic [2:0]           cnt_add [NUM_ENTRIES];
  logic [CNT_WIDTH:0]   cnt_sum [NUM_ENTRIES];
`endif

  // Table register writes; out-of-range rows and unknown columns are dropped
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tab_tag[e]  <= '0;
        tab_base[e] <= '0;
        tab_len[e]  <= '0;
      end
      tab_valid <= '0;
    end else if (wr_en) begin
      case (col)
        15'd0:   tab_base[row_idx]  <= wdata[ADDR_WIDTH-1:0];
        15'd1:   tab_len[row_idx]   <= wdata[ADDR_WIDTH-1:0];
        15'd2:   tab_tag[row_idx]   <= wdata[TAG_WIDTH-1:0];
        15'd3:   tab_valid[row_idx] <= wdata[0];
        default: ;
      endcase
    end
  end

  // Combinational register read, zero-extended, independent of sel
  always_comb begin
    rdata = '0;
    if (row_in) begin
      case (col)
        15'd0:   rdata = 64'(tab_base[row_idx]);
        15'd1:   rdata = 64'(tab_len[row_idx]);
        15'd2:   rdata = 64'(tab_tag[row_idx]);
        15'd3:   rdata = 64'(tab_valid[row_idx]);
`ifdef MIG_CP_PTAB_STATS_EN
        15'd4:   rdata = 64'(cnt_q[row_idx]);
`endif
        default: rdata = '0;
      endcase
    end
  end

  // Tag match with lowest-index priority (scan high to low so the lowest hit is kept)
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      lk_hit[p] = 1'b0;
      lk_idx[p] = '0;
      for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
        if (tab_valid[e] && (tab_tag[e] == req_tag[p*TAG_WIDTH +: TAG_WIDTH])) begin
          lk_hit[p] = 1'b1;
          lk_idx[p] = IDX_W'(e);
        end
      end
    end
  end

  // Handshake and flow control per channel
  always_comb begin
    s2_ready  = '0;
    s1_adv    = '0;
    req_ready = '0;
    accept    = '0;
    resp_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      s2_ready[p]  = !s2_valid[p] || resp_ready[p];
      s1_adv[p]    = s1_valid[p] && s2_ready[p];
      req_ready[p] = !s1_valid[p] || s1_adv[p];
      accept[p]    = req_valid[p] && req_ready[p];
      resp_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = s2_addr[p];
    end
  end

  assign resp_valid = s2_valid;
  assign resp_hit   = s2_hit;
  assign resp_oob   = s2_oob;

  // Stage 1: capture offset plus a snapshot of the matched entry's base/len
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_valid <= '0;
      s1_hit   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        s1_off[p]  <= '0;
        s1_base[p] <= '0;
        s1_len[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          s1_valid[p] <= 1'b1;
          s1_hit[p]   <= lk_hit[p];
          s1_off[p]   <= req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
          s1_base[p]  <= tab_base[lk_idx[p]];
          s1_len[p]   <= tab_len[lk_idx[p]];
        end else if (s1_adv[p]) begin
          s1_valid[p] <= 1'b0;
        end
      end
    end
  end

  // Stage 2: translate and bounds-check; holds while the response is stalled
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s2_valid <= '0;
      s2_hit   <= '0;
      s2_oob   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) s2_addr[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (s2_ready[p]) begin
          s2_valid[p] <= s1_valid[p];
          if (s1_valid[p]) begin
            s2_hit[p]  <= s1_hit[p];
            s2_oob[p]  <= s1_hit[p] && (s1_off[p] >= s1_len[p]);
            s2_addr[p] <= s1_hit[p] ? (s1_base[p] + s1_off[p]) : s1_off[p];
          end
        end
      end
    end
  end

`ifdef MIG_CP_PTAB_STATS_EN
  // Sum same-cycle hits per entry and form the saturating next count
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      cnt_add[e] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p] && lk_hit[p] && (lk_idx[p] == IDX_W'(e))) cnt_add[e] = cnt_add[e] + 3'd1;
      end
      cnt_sum[e] = {1'b0, cnt_q[e]} + (CNT_WIDTH+1)'(cnt_add[e]);
    end
  end

  // Hit counters; a clearing write wins over a same-cycle hit
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int e = 0; e < NUM_ENTRIES; e++) cnt_q[e] <= '0;
    end else begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (wr_en && (col == 15'd4) && (row_idx == IDX_W'(e))) cnt_q[e] <= '0;
        else if (cnt_sum[e][CNT_WIDTH]) cnt_q[e] <= '1;
        else cnt_q[e] <= cnt_sum[e][CNT_WIDTH-1:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mig_cp_ptab_xlat.sv
// tb/tb_mig_cp_ptab_xlat.sv - self-checking bench for mig_cp_ptab_xlat
module tb_mig_cp_ptab_xlat;

  localparam int NE = 8;
  localparam int NP = 2;
  localparam int TW = 16;
  localparam int AW = 32;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            sel, wen;
  logic [14:0]     col, row;
  logic [63:0]     wdata, rdata;
  logic [NP-1:0]   req_valid, req_ready, resp_valid, resp_ready, resp_hit, resp_oob;
  logic [NP*TW-1:0] req_tag;
  logic [NP*AW-1:0] req_addr, resp_addr;

  int n_vec = 0;
  int n_err = 0;

  logic [TW-1:0] m_tag   [NE];
  logic [AW-1:0] m_base  [NE];
  logic [AW-1:0] m_len   [NE];
  logic          m_valid [NE];
  logic [33:0]   exp_q0[$];
  logic [33:0]   exp_q1[$];

  always #5 aclk = ~aclk;

  mig_cp_ptab_xlat dut (
    .aclk(aclk), .aresetn(aresetn), .sel(sel), .col(col), .row(row), .wdata(wdata),
    .wen(wen), .rdata(rdata), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_addr(req_addr), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_addr(resp_addr), .resp_hit(resp_hit), .resp_oob(resp_oob)
  );

  // Reference: first valid entry with equal tag wins; {hit, oob, addr}
  function automatic logic [33:0] model_lookup(input logic [TW-1:0] tag, input logic [AW-1:0] off);
    logic [AW-1:0] sum;
    for (int i = 0; i < NE; i++) begin
      if (m_valid[i] && m_tag[i] == tag) begin
        sum = m_base[i] + off;
        return {1'b1, (off >= m_len[i]), sum};
      end
    end
    return {1'b0, 1'b0, off};
  endfunction

  task automatic model_write(input int r, input int c, input logic [63:0] d);
    if (r < NE) begin
      case (c)
        0: m_base[r] = d[31:0];
        1: m_len[r] = d[31:0];
        2: m_tag[r] = d[15:0];
        3: m_valid[r] = d[0];
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_tag[i] = '0; m_base[i] = '0; m_len[i] = '0; m_valid[i] = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic reg_write(input int r, input int c, input logic [63:0] d);
    @(negedge aclk);
    sel = 1'b1; wen = 1'b1; row = 15'(r); col = 15'(c); wdata = d;
    @(negedge aclk);
    model_write(r, c, d);
    sel = 1'b0; wen = 1'b0;
  endtask

  task automatic reg_read(input int r, input int c, output logic [63:0] v);
    @(negedge aclk);
    row = 15'(r); col = 15'(c);
    #1;
    v = rdata;
  endtask

  task automatic do_req(input int ch, input logic [TW-1:0] tag, input logic [AW-1:0] off,
                        output logic early, output logic vld, output logic [AW-1:0] a,
                        output logic h, output logic o);
    @(negedge aclk);
    resp_ready = '1;
    req_valid[ch] = 1'b1;
    req_tag[ch*TW +: TW] = tag;
    req_addr[ch*AW +: AW] = off;
    @(negedge aclk);
    req_valid[ch] = 1'b0;
    #1;
    early = resp_valid[ch];
    @(negedge aclk);
    #1;
    vld = resp_valid[ch];
    a = resp_addr[ch*AW +: AW];
    h = resp_hit[ch];
    o = resp_oob[ch];
  endtask

  task automatic test_reset();
    logic [63:0] v;
    aresetn = 1'b0; sel = 1'b0; wen = 1'b0; col = '0; row = '0; wdata = '0;
    req_valid = '0; req_tag = '0; req_addr = '0; resp_ready = '1;
    repeat (3) @(negedge aclk);
    #1;
    n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    n_vec++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL reset_req_ready: got %b want 11", req_ready); end
    n_vec++; if ({resp_addr, resp_hit, resp_oob} !== '0) begin n_err++; $display("FAIL reset_resp_fields: got %h/%b/%b want 0", resp_addr, resp_hit, resp_oob); end
    reg_read(0, 3, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL reset_valid_reg: got %h want 0", v); end
    @(negedge aclk);
    aresetn = 1'b1;
    model_reset();
  endtask

  task automatic test_translate();
    logic e, vl, h, o;
    logic [AW-1:0] a;
    reg_write(3, 2, 64'h12);
    reg_write(3, 0, 64'h8000_0000);
    reg_write(3, 1, 64'h1000);
    reg_write(3, 3, 64'h1);
    do_req(0, 16'h0012, 32'h40, e, vl, a, h, o);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL latency_early: got %b want 0", e); end
    n_vec++; if ({vl, h, o, a} !== {1'b1, 1'b1, 1'b0, 32'h8000_0040}) begin n_err++; $display("FAIL hit_inbound: got v%b h%b o%b %h want v1 h1 o0 80000040", vl, h, o, a); end
    do_req(0, 16'h0012, 32'h1000, e, vl, a, h, o);
    n_vec++; if ({vl, h, o, a} !== {1'b1, 1'b1, 1'b1, 32'h8000_1000}) begin n_err++; $display("FAIL hit_oob_edge: got v%b h%b o%b %h want v1 h1 o1 80001000", vl, h, o, a); end
    do_req(0, 16'h0099, 32'h20, e, vl, a, h, o);
    n_vec++; if ({vl, h, o, a} !== {1'b1, 1'b0, 1'b0, 32'h20}) begin n_err++; $display("FAIL miss_passthru: got v%b h%b o%b %h want v1 h0 o0 20", vl, h, o, a); end
    reg_write(6, 2, 64'h33);
    reg_write(6, 0, 64'h10);
    reg_write(6, 1, 64'h0);
    reg_write(6, 3, 64'h1);
    do_req(1, 16'h0033, 32'h0, e, vl, a, h, o);
    n_vec++; if ({vl, h, o, a} !== {1'b1, 1'b1, 1'b1, 32'h10}) begin n_err++; $display("FAIL len_zero_oob: got v%b h%b o%b %h want v1 h1 o1 10", vl, h, o, a); end
  endtask

  task automatic test_priority();
    logic e, vl, h, o;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      reg_write(k ? 5 : 1, 2, 64'h7);
      reg_write(k ? 5 : 1, 0, k ? 64'h500 : 64'h100);
      reg_write(k ? 5 : 1, 1, 64'h1000);
      reg_write(k ? 5 : 1, 3, 64'h1);
    end
    do_req(1, 16'h7, 32'h0, e, vl, a, h, o);
    n_vec++; if ({vl, h, a} !== {1'b1, 1'b1, 32'h100}) begin n_err++; $display("FAIL prio_lowest: got v%b h%b %h want v1 h1 100", vl, h, a); end
    reg_write(1, 3, 64'h0);
    do_req(1, 16'h7, 32'h0, e, vl, a, h, o);
    n_vec++; if ({vl, h, a} !== {1'b1, 1'b1, 32'h500}) begin n_err++; $display("FAIL prio_next: got v%b h%b %h want v1 h1 500", vl, h, a); end
  endtask

  task automatic test_back_to_back();
    int sent, n_got;
    logic [AW-1:0] got [8];
    sent = 0; n_got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge aclk);
      resp_ready[1] = (cyc >= 3);
      req_valid[1] = (sent < 4);
      req_tag[TW +: TW] = 16'h7;
      req_addr[AW +: AW] = AW'(sent * 4);
      #1;
      if (cyc == 2) begin
        n_vec++; if (req_ready[1] !== 1'b0 || sent != 2) begin n_err++; $display("FAIL bp_ready_drop: got ready %b accepts %0d want ready 0 accepts 2", req_ready[1], sent); end
      end
      if (cyc == 2 || cyc == 3) begin
        n_vec++; if (resp_valid[1] !== 1'b1 || resp_addr[AW +: AW] !== 32'h500) begin n_err++; $display("FAIL bp_hold_c%0d: got v%b %h want v1 500", cyc, resp_valid[1], resp_addr[AW +: AW]); end
      end
      if (resp_valid[1] && resp_ready[1] && n_got < 8) begin got[n_got] = resp_addr[AW +: AW]; n_got++; end
      if (req_valid[1] && req_ready[1]) sent++;
    end
    req_valid[1] = 1'b0;
    resp_ready = '1;
    n_vec++; if (n_got != 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", n_got); end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      n_vec++; if (got[i] !== 32'h500 + AW'(i * 4)) begin n_err++; $display("FAIL bp_order%0d: got %h want %h", i, got[i], 32'h500 + AW'(i * 4)); end
    end
  endtask

  task automatic test_write_race();
    logic e, vl, h, o;
    logic [AW-1:0] a;
    logic [63:0] v;
    @(negedge aclk);
    resp_ready = '1;
    req_valid[0] = 1'b1; req_tag[0 +: TW] = 16'h12; req_addr[0 +: AW] = 32'h40;
    sel = 1'b1; wen = 1'b1; row = 15'd3; col = 15'd0; wdata = 64'h9000_0000;
    @(negedge aclk);
    req_valid[0] = 1'b0; sel = 1'b0; wen = 1'b0;
    model_write(3, 0, 64'h9000_0000);
    @(negedge aclk);
    #1;
    n_vec++; if (resp_valid[0] !== 1'b1 || resp_addr[0 +: AW] !== 32'h8000_0040) begin n_err++; $display("FAIL race_old_base: got v%b %h want v1 80000040", resp_valid[0], resp_addr[0 +: AW]); end
    do_req(0, 16'h12, 32'h40, e, vl, a, h, o);
    n_vec++; if ({vl, a} !== {1'b1, 32'h9000_0040}) begin n_err++; $display("FAIL race_new_base: got v%b %h want v1 90000040", vl, a); end
  endtask

  task automatic test_regmap();
    logic [63:0] v;
    reg_read(3, 0, v);
    n_vec++; if (v !== 64'h0000_0000_9000_0000) begin n_err++; $display("FAIL rd_base: got %h want 90000000", v); end
    reg_read(3, 2, v);
    n_vec++; if (v !== 64'h12) begin n_err++; $display("FAIL rd_tag: got %h want 12", v); end
    reg_read(20, 0, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL rd_row_oor: got %h want 0", v); end
    reg_read(3, 7, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL rd_bad_col: got %h want 0", v); end
    reg_write(20, 0, 64'hdead);
    reg_read(4, 0, v);
    n_vec++; if (v !== 64'(m_base[4])) begin n_err++; $display("FAIL wr_row_oor_alias: got %h want %h", v, m_base[4]); end
    reg_write(3, 1, 64'hFFFF_FFFF_0000_2000);
    reg_read(3, 1, v);
    n_vec++; if (v !== 64'h2000) begin n_err++; $display("FAIL wr_truncate: got %h want 2000", v); end
  endtask

  task automatic test_stats();
    logic [63:0] v, want;
`ifdef MIG_CP_PTAB_STATS_EN
    want = 64'd2;
`else
    want = 64'd0;
`endif
    reg_write(3, 4, 64'h0);
    reg_read(3, 4, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL stats_clear0: got %h want 0", v); end
    @(negedge aclk);
    resp_ready = '1;
    req_valid = 2'b11;
    req_tag = {16'h12, 16'h12};
    req_addr = {32'h20, 32'h10};
    @(negedge aclk);
    req_valid = '0;
    reg_read(3, 4, v);
    n_vec++; if (v !== want) begin n_err++; $display("FAIL stats_dual_hit: got %h want %h", v, want); end
    reg_write(3, 4, 64'h5);
    reg_read(3, 4, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL stats_wr_clear: got %h want 0", v); end
  endtask

  task automatic test_random();
    logic [33:0] exp, got;
    logic [33:0] prev [NP];
    logic        held [NP];
    logic        wr;
    int          occ, wr_r, wr_c;
    logic [63:0] wr_d;
    for (int e = 0; e < NE; e++) begin
      reg_write(e, 2, 64'($urandom_range(1, 4)));
      reg_write(e, 0, 64'($urandom));
      reg_write(e, 1, 64'($urandom_range(0, 512)));
      reg_write(e, 3, 64'($urandom_range(0, 1)));
    end
    for (int p = 0; p < NP; p++) begin held[p] = 1'b0; prev[p] = '0; end
    wr_r = 0; wr_c = 0; wr_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge aclk);
      for (int p = 0; p < NP; p++) begin
        req_valid[p] = (cyc < 360) && ($urandom_range(0, 9) < 7);
        req_tag[p*TW +: TW] = TW'($urandom_range(1, 5));
        req_addr[p*AW +: AW] = AW'($urandom_range(0, 600));
        resp_ready[p] = (cyc >= 360) || ($urandom_range(0, 9) < 6);
      end
      wr = (cyc < 360) && ($urandom_range(0, 4) == 0);
      if (wr) begin
        wr_r = $urandom_range(0, NE - 1);
        wr_c = $urandom_range(0, 3);
        wr_d = {$urandom, $urandom};
        if (wr_c == 2) wr_d = 64'($urandom_range(1, 5));
        if (wr_c == 1) wr_d = 64'($urandom_range(0, 512));
        sel = 1'b1; wen = 1'b1; row = 15'(wr_r); col = 15'(wr_c); wdata = wr_d;
      end else begin
        sel = 1'b0; wen = 1'b0;
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        occ = (p == 0) ? exp_q0.size() : exp_q1.size();
        got = {resp_hit[p], resp_oob[p], resp_addr[p*AW +: AW]};
        n_vec++; if (req_ready[p] !== ((occ < 2) || resp_ready[p])) begin n_err++; $display("FAIL rnd_ready ch%0d cyc%0d: got %b want %b", p, cyc, req_ready[p], (occ < 2) || resp_ready[p]); end
        if (held[p]) begin
          n_vec++; if (resp_valid[p] !== 1'b1 || got !== prev[p]) begin n_err++; $display("FAIL rnd_hold ch%0d cyc%0d: got v%b %h want v1 %h", p, cyc, resp_valid[p], got, prev[p]); end
        end
        if (resp_valid[p] && resp_ready[p]) begin
          n_vec++;
          if (occ == 0) begin
            n_err++; $display("FAIL rnd_spurious ch%0d cyc%0d: got resp %h want none", p, cyc, got);
          end else begin
            exp = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got !== exp) begin n_err++; $display("FAIL rnd_resp ch%0d cyc%0d: got %h want %h", p, cyc, got, exp); end
          end
        end
        held[p] = resp_valid[p] && !resp_ready[p];
        prev[p] = got;
        if (req_valid[p] && req_ready[p]) begin
          exp = model_lookup(req_tag[p*TW +: TW], req_addr[p*AW +: AW]);
          if (p == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        end
      end
      if (wr) model_write(wr_r, wr_c, wr_d);
    end
    sel = 1'b0; wen = 1'b0; req_valid = '0;
    n_vec++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin n_err++; $display("FAIL rnd_drain: got %0d/%0d pending want 0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v;
    int stray;
    reg_write(3, 2, 64'h12);
    reg_write(3, 3, 64'h1);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge aclk);
      resp_ready = '0;
      req_valid = 2'b11;
      req_tag = {16'h12, 16'h12};
      req_addr = {32'h8, 32'h4};
    end
    @(negedge aclk);
    aresetn = 1'b0;
    req_valid = '0;
    @(negedge aclk);
    #1;
    n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL rstmid_valid: got %b want 00", resp_valid); end
    n_vec++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL rstmid_ready: got %b want 11", req_ready); end
    reg_read(3, 3, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL rstmid_table: got %h want 0", v); end
    reg_read(3, 4, v);
    n_vec++; if (v !== 64'd0) begin n_err++; $display("FAIL rstmid_counter: got %h want 0", v); end
    @(negedge aclk);
    aresetn = 1'b1;
    resp_ready = '1;
    model_reset();
    stray = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge aclk);
      #1;
      if (resp_valid !== 2'b00) stray++;
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL rstmid_drop: got %0d stray responses want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_translate();
    test_priority();
    test_back_to_back();
    test_write_race();
    test_regmap();
    test_stats();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
